// File: rtl/fifo_write_arbiter.sv
// rtl/fifo_write_arbiter.sv - round-robin burst arbiter sharing one FIFO write port among producer channels
// Optional per-channel accepted-word counters: define FIFO_WRITE_ARBITER_STATS_EN.
module fifo_write_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int CH_CNT     = 4,
    parameter int MAX_BURST  = 4,
    localparam int IW = (CH_CNT > 1) ? $clog2(CH_CNT) : 1,
    localparam int CW = $clog2(MAX_BURST + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [CH_CNT*DATA_WIDTH-1:0] ch_data_i,
    input  logic [CH_CNT-1:0]            ch_en_i,
    output logic [CH_CNT-1:0]            ch_wait_o,
    output logic [DATA_WIDTH-1:0]        fifo_data_o,
    output logic                         fifo_en_o,
    input  logic                         fifo_wait_i,
    output logic                         grant_valid_o,
    output logic [IW-1:0]                grant_idx_o
`ifdef FIFO_WRITE_ARBITER_STATS_EN
    ,
    output logic [CH_CNT*16-1:0]         ch_words_o,
    input  logic                         stats_clr_i
`endif
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q;
    logic [IW-1:0] gnt_q;
    logic [IW-1:0] last_gnt_q;
    logic [CW-1:0] beat_cnt_q;

    logic          en_g;
    logic          xfer;
    logic          rr_found;
    logic [IW-1:0] rr_pick;
    logic [IW-1:0] cand;

    assign en_g = ch_en_i[gnt_q];
    assign xfer = (state_q == BUSY) && en_g && !fifo_wait_i;

    // Search starts just after the last owner, so it ends up lowest priority.
    always_comb begin
        rr_found = 1'b0;
        rr_pick  = '0;
        cand     = '0;
        for (int k = 1; k <= CH_CNT; k++) begin
            cand = IW'((int'(last_gnt_q) + k) % CH_CNT);
            if (!rr_found && ch_en_i[cand]) begin
                rr_found = 1'b1;
                rr_pick  = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            gnt_q      <= '0;
            last_gnt_q <= IW'(CH_CNT - 1);
            beat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rr_found) begin
                        gnt_q      <= rr_pick;
                        state_q    <= BUSY;
                        beat_cnt_q <= '0;
                    end
                end
                BUSY: begin
                    if (!en_g || (xfer && beat_cnt_q == CW'(MAX_BURST - 1))) begin
                        state_q    <= IDLE;
                        last_gnt_q <= gnt_q;
                        beat_cnt_q <= '0;
                    end else if (xfer) begin
                        beat_cnt_q <= beat_cnt_q + CW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        ch_wait_o   = '1;
        fifo_en_o   = 1'b0;
        fifo_data_o = '0;
        if (state_q == BUSY) begin
            fifo_en_o = en_g;
            for (int j = 0; j < CH_CNT; j++) begin
                if (IW'(j) == gnt_q) begin
                    fifo_data_o  = ch_data_i[j*DATA_WIDTH +: DATA_WIDTH];
                    ch_wait_o[j] = fifo_wait_i;
                end
            end
        end
    end

    assign grant_valid_o = (state_q == BUSY);
    assign grant_idx_o   = (state_q == BUSY) ? gnt_q : '0;

`ifdef FIFO_WRITE_ARBITER_STATS_EN
    logic [15:0] words_q [CH_CNT];

    // Clear wins over a same-cycle increment.
    always_ff @(posedge clk) begin
        if (!rst_n || stats_clr_i) begin
            for (int i = 0; i < CH_CNT; i++) begin
                words_q[i] <= '0;
            end
        end else if (xfer) begin
            words_q[gnt_q] <= words_q[gnt_q] + 16'd1;
        end
    end

    for (genvar g = 0; g < CH_CNT; g++) begin : g_words
        assign ch_words_o[g*16 +: 16] = words_q[g];
    end
`endif

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Round-robin arbiter that shares one FIFO write port between CH_CNT producer channels.
- All channels use the data/en/wait handshake: a word transfers in a cycle where en=1 and wait=0.
- The winning channel holds the FIFO port for a burst of up to MAX_BURST words, then releases it.
- Sits between the producer channels and the dataIn port of a BRAM FIFO.

Parameters:
- DATA_WIDTH, 8, width of one data word.
- CH_CNT, 4, number of producer channels (2..16).
- MAX_BURST, 4, maximum words transferred per grant (>=1).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- ch_data  in  CH_CNT*DATA_WIDTH  channel data; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ch_en  in  CH_CNT  per-channel request / word valid.
- ch_wait  out  CH_CNT  per-channel backpressure; 1 = word not accepted this cycle.
- fifo_data  out  DATA_WIDTH  to FIFO dataIn_data.
- fifo_en  out  1  to FIFO dataIn_en.
- fifo_wait  in  1  from FIFO dataIn_wait (1 = full).
- grant_valid  out  1  1 while a channel owns the port.
- grant_idx  out  clog2(CH_CNT)  index of the owning channel; 0 when grant_valid=0.

Behaviour:
- Registered state: state {IDLE, BUSY}; gnt (index); last_gnt (index); beat_cnt, width clog2(MAX_BURST+1).
- Reset (rst_n=0 at a clock edge):
  - state=IDLE, gnt=0, last_gnt=CH_CNT-1, beat_cnt=0.
  - Resulting outputs: ch_wait=all 1s, fifo_en=0, fifo_data=0, grant_valid=0, grant_idx=0.
  - Reset mid-burst aborts the burst immediately; the word in that cycle is not counted, and the next grant starts from channel 0.
- IDLE:
  - All ch_wait=1, fifo_en=0, fifo_data=0.
  - If any ch_en=1: gnt <= first i with ch_en[i]=1, searching last_gnt+1, last_gnt+2, ... modulo CH_CNT; state <= BUSY; beat_cnt <= 0.
  - If no ch_en=1: stay in IDLE.
  - Arbitration latency is 1 cycle: a request seen in cycle t can transfer at the earliest in cycle t+1.
- BUSY (g = gnt):
  - Combinational outputs: fifo_data = ch_data[g]; fifo_en = ch_en[g]; ch_wait[g] = fifo_wait; ch_wait[j]=1 for all j != g.
  - Transfer = ch_en[g] & ~fifo_wait. On a transfer, beat_cnt increments.
  - Release, evaluated each cycle; any of these causes state <= IDLE, last_gnt <= g, beat_cnt <= 0:
    - transfer with beat_cnt == MAX_BURST-1 (burst complete);
    - ch_en[g]=0 (channel dropped its request).
  - fifo_wait=1 with ch_en[g]=1: hold the grant, no count; a stalled channel is never preempted.
  - After a release there is one IDLE bubble cycle before the next grant.
- Fairness: a channel that has just been released is the lowest priority at the next arbitration. With all channels requesting continuously, grants rotate 0,1,2,...,CH_CNT-1,0,...
- Words are never duplicated or dropped: each accepted word corresponds to exactly one cycle with fifo_en=1 and fifo_wait=0.
- grant_valid = (state==BUSY); grant_idx = gnt when BUSY, else 0.

Optional Feature:
- Macro: FIFO_WRITE_ARBITER_STATS_EN.
- Defined:
  - Adds output ch_words, width CH_CNT*16. Per-channel 16-bit counter of accepted words, wrapping modulo 2^16, cleared by reset.
  - Adds input stats_clr (1 bit). stats_clr=1 zeroes all counters next cycle; clear has priority over a simultaneous increment.
- Not defined: neither port exists, no counter logic is synthesised, and all other behaviour is identical.

Test Plan:
- Reset, then ch_en=4'b0001 with fifo_wait=0 continuously, words 0xA0..0xA5 -> grant_idx=0. Words 0xA0..0xA3 transfer on 4 consecutive cycles starting 1 cycle after request. One IDLE bubble. Regrant; 0xA4, 0xA5 follow.
- ch_en=4'b1111, fifo_wait=0, MAX_BURST=4 -> grant order 0,1,2,3,0. Exactly 4 words per grant. 5 cycles per grant, including the bubble.
- Channel 2 granted, fifo_wait=1 for 3 cycles mid-burst -> ch_wait[2]=1 during the stall, beat_cnt frozen. Grant held. Burst completes with exactly 4 words after the stall.
- Channel 1 granted, sends 2 words, then ch_en[1]=0 while ch_en[3]=1 -> release after 2 words. Next grant is channel 3, with last_gnt=1.
- rst_n=0 asserted during the 3rd beat of a channel 0 burst -> next cycle state=IDLE, all ch_wait=1, fifo_en=0. After reset with all channels requesting, the first grant is channel 0.
- With FIFO_WRITE_ARBITER_STATS_EN defined: 10 words from ch0, 3 from ch2 -> ch_words slots = {0, 3, 0, 10} (ch3..ch0). Pulse stats_clr -> all counts 0 next cycle.
